// File: rtl/fc_sequencer_if.sv
// Bundled host, stream and network-side signals of fc_sequencer.
// master: the sequencer itself; slave: host/stream side and fc network.
interface fc_sequencer_if #(
    parameter int unsigned N = 27
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         s_train;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;
    logic         e_valid;
    logic         e_ready;
    logic [N-1:0] e_data;
    logic         g_valid;
    logic         g_ready;
    logic [N-1:0] g_data;
    logic         fc_fd_prop;
    logic         fc_bk_prop;
    logic [N-1:0] fc_fin;
    logic [N-1:0] fc_bin;
    logic         fc_oscillator;
    logic [N-1:0] fc_fout;
    logic [N-1:0] fc_bout;
    logic         fc_fd_done;
    logic         fc_bk_done;
    logic         busy;
    logic [15:0]  step_count;
    logic         err_timeout;

    modport master (
        input  s_valid, s_data, s_train, m_ready, e_valid, e_data, g_ready,
               fc_fout, fc_bout, fc_fd_done, fc_bk_done,
        output s_ready, m_valid, m_data, e_ready, g_valid, g_data,
               fc_fd_prop, fc_bk_prop, fc_fin, fc_bin, fc_oscillator,
               busy, step_count, err_timeout
    );

    modport slave (
        output s_valid, s_data, s_train, m_ready, e_valid, e_data, g_ready,
               fc_fout, fc_bout, fc_fd_done, fc_bk_done,
        input  s_ready, m_valid, m_data, e_ready, g_valid, g_data,
               fc_fd_prop, fc_bk_prop, fc_fin, fc_bin, fc_oscillator,
               busy, step_count, err_timeout
    );
endinterface

// File: rtl/fc_sequencer.sv
// Forward/backward step controller for one fc network instance.
// Define FC_SEQ_TIMEOUT_EN to abort wait states after TIMEOUT_CYC cycles without done.
module fc_sequencer #(
    parameter int unsigned N           = 27,
    parameter int unsigned OSC_DIV     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic            clk_in,
    input logic            rst_in,
    fc_sequencer_if.master bus
);

    if (OSC_DIV < 1 || OSC_DIV > 255) begin : g_osc_div_check
        $error("fc_sequencer: OSC_DIV must be in 1..255");
    end
    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("fc_sequencer: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle, StFwdStart, StFwdWait, StFwdOut, StErrWait, StBkStart, StBkWait, StBkOut
    } state_e;

    state_e       state_q, state_d;
    logic         train_q;
    logic [N-1:0] fin_q, bin_q, mdata_q, gdata_q;
    logic [15:0]  step_q;
    logic [7:0]   osc_cnt_q;
    logic         osc_q;
    logic         err_q;

    logic s_ready, m_valid, e_ready, g_valid, fd_prop, bk_prop, busy;
    logic s_accept, e_accept, fd_capture, bk_capture, step_done;
    logic timeout_hit;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done seen in a wait state always beats a timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (bus.s_valid) state_d = StFwdStart;
            StFwdStart: state_d = StFwdWait;
            StFwdWait: begin
                if (bus.fc_fd_done) state_d = StFwdOut;
                else if (timeout_hit) state_d = StIdle;
            end
            StFwdOut:   if (bus.m_ready) state_d = train_q ? StErrWait : StIdle;
            StErrWait:  if (bus.e_valid) state_d = StBkStart;
            StBkStart:  state_d = StBkWait;
            StBkWait: begin
                if (bus.fc_bk_done) state_d = StBkOut;
                else if (timeout_hit) state_d = StIdle;
            end
            StBkOut:    if (bus.g_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output decode: handshake outputs come from the registered state only
    always_comb begin
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        e_ready    = 1'b0;
        g_valid    = 1'b0;
        fd_prop    = 1'b0;
        bk_prop    = 1'b0;
        busy       = 1'b1;
        s_accept   = 1'b0;
        e_accept   = 1'b0;
        fd_capture = 1'b0;
        bk_capture = 1'b0;
        step_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_ready  = 1'b1;
                busy     = 1'b0;
                s_accept = bus.s_valid;
            end
            StFwdStart: fd_prop = 1'b1;
            StFwdWait:  fd_capture = bus.fc_fd_done;
            StFwdOut: begin
                m_valid   = 1'b1;
                step_done = bus.m_ready & ~train_q;
            end
            StErrWait: begin
                e_ready  = 1'b1;
                e_accept = bus.e_valid;
            end
            StBkStart:  bk_prop = 1'b1;
            StBkWait:   bk_capture = bus.fc_bk_done;
            StBkOut: begin
                g_valid   = 1'b1;
                step_done = bus.g_ready;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fin_q   <= '0;
            bin_q   <= '0;
            mdata_q <= '0;
            gdata_q <= '0;
            train_q <= 1'b0;
            step_q  <= '0;
        end else begin
            if (s_accept) begin
                fin_q   <= bus.s_data;
                train_q <= bus.s_train;
            end
            if (e_accept) bin_q <= bus.e_data;
            if (fd_capture) mdata_q <= bus.fc_fout;
            if (bk_capture) gdata_q <= bus.fc_bout;
            if (step_done) step_q <= step_q + 16'd1;
        end
    end

    // Free-running oscillator divider, independent of the sequencer state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            osc_cnt_q <= '0;
            osc_q     <= 1'b0;
        end else if (osc_cnt_q == 8'(OSC_DIV - 1)) begin
            osc_cnt_q <= '0;
            osc_q     <= ~osc_q;
        end else begin
            osc_cnt_q <= osc_cnt_q + 8'd1;
        end
    end

`ifdef FC_SEQ_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);

    logic [WaitW-1:0] wait_cnt_q;
    logic             in_wait;

    assign in_wait     = (state_q == StFwdWait) || (state_q == StBkWait);
    assign timeout_hit = in_wait && !(fd_capture || bk_capture) &&
                         (wait_cnt_q == WaitW'(TIMEOUT_CYC - 1));

    // Counter sits at zero outside the wait states, so entry always starts from zero
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= in_wait ? wait_cnt_q + WaitW'(1) : '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    assign bus.s_ready       = s_ready;
    assign bus.m_valid       = m_valid;
    assign bus.e_ready       = e_ready;
    assign bus.g_valid       = g_valid;
    assign bus.fc_fd_prop    = fd_prop;
    assign bus.fc_bk_prop    = bk_prop;
    assign bus.busy          = busy;
    assign bus.m_data        = mdata_q;
    assign bus.g_data        = gdata_q;
    assign bus.fc_fin        = fin_q;
    assign bus.fc_bin        = bin_q;
    assign bus.fc_oscillator = osc_q;
    assign bus.step_count    = step_q;
    assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Randomized self-checking bench for fc_sequencer against a transaction-level model.
module tb_fc_sequencer;
    localparam int unsigned N           = 27;
    localparam int unsigned OSC_DIV     = 4;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fc_sequencer_if #(.N(N)) bus ();

    fc_sequencer #(.N(N), .OSC_DIV(OSC_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected observable behaviour, advanced by the stimulus as each transaction step completes
    bit           exp_s_ready = 1'b1, exp_m_valid = 1'b0, exp_e_ready = 1'b0, exp_g_valid = 1'b0;
    bit           exp_fd_prop = 1'b0, exp_bk_prop = 1'b0, exp_err = 1'b0;
    logic [N-1:0] exp_fin = '0, exp_bin = '0, exp_mdata = '0, exp_gdata = '0;
    int           exp_steps = 0;
    int           k = 0;       // clock edges since reset release
    int           fd_pulses = 0, bk_pulses = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void set_exp(input bit sr, input bit mv, input bit er, input bit gv,
                                    input bit fp, input bit bp);
        exp_s_ready = sr;
        exp_m_valid = mv;
        exp_e_ready = er;
        exp_g_valid = gv;
        exp_fd_prop = fp;
        exp_bk_prop = bp;
    endfunction

    function automatic void reset_model();
        set_exp(1, 0, 0, 0, 0, 0);
        exp_fin   = '0;
        exp_bin   = '0;
        exp_mdata = '0;
        exp_gdata = '0;
        exp_steps = 0;
        exp_err   = 1'b0;
    endfunction

    function automatic logic [N-1:0] rnd27();
        return N'($urandom);
    endfunction

    function automatic bit coin();
        return 1'($urandom_range(0, 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else k <= k + 1;
    end

    always @(posedge clk) begin
        if (bus.fc_fd_prop === 1'b1) fd_pulses <= fd_pulses + 1;
        if (bus.fc_bk_prop === 1'b1) bk_pulses <= bk_pulses + 1;
    end

    // Cycle-by-cycle comparison against the model, half a clock away from the active edge
    always @(negedge clk) begin
        chk("s_ready", 32'(bus.s_ready), 32'(exp_s_ready));
        chk("busy", 32'(bus.busy), 32'(!exp_s_ready));
        chk("m_valid", 32'(bus.m_valid), 32'(exp_m_valid));
        chk("e_ready", 32'(bus.e_ready), 32'(exp_e_ready));
        chk("g_valid", 32'(bus.g_valid), 32'(exp_g_valid));
        chk("fd_prop", 32'(bus.fc_fd_prop), 32'(exp_fd_prop));
        chk("bk_prop", 32'(bus.fc_bk_prop), 32'(exp_bk_prop));
        chk("fc_fin", 32'(bus.fc_fin), 32'(exp_fin));
        chk("fc_bin", 32'(bus.fc_bin), 32'(exp_bin));
        chk("m_data", 32'(bus.m_data), 32'(exp_mdata));
        chk("g_data", 32'(bus.g_data), 32'(exp_gdata));
        chk("step_count", 32'(bus.step_count), 32'(exp_steps[15:0]));
        chk("err_timeout", 32'(bus.err_timeout), 32'(exp_err));
        chk("oscillator", 32'(bus.fc_oscillator), 32'((k / OSC_DIV) % 2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.s_valid    = 1'b0;
        bus.s_train    = 1'b0;
        bus.m_ready    = 1'b0;
        bus.e_valid    = 1'b0;
        bus.g_ready    = 1'b0;
        bus.fc_fd_done = 1'b0;
        bus.fc_bk_done = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid    = 1'b0;
            bus.s_data     = rnd27();
            bus.fc_fd_done = coin();
            bus.fc_bk_done = coin();
            bus.e_valid    = coin();
            bus.e_data     = rnd27();
            bus.m_ready    = coin();
            bus.g_ready    = coin();
            bus.fc_fout    = rnd27();
            bus.fc_bout    = rnd27();
            tick();
        end
        clear_inputs();
    endtask

    // One full step; abort=1 drops reset during the backward wait and leaves the model in reset.
    task automatic run_step(input logic [N-1:0] din, input bit train, input logic [N-1:0] fout,
                            input logic [N-1:0] bout, input logic [N-1:0] edata,
                            input int flat, input int mstall, input int egap, input int blat,
                            input int gstall, input bit noisy, input bit abort);
        bus.s_valid = 1'b1; bus.s_data = din; bus.s_train = train;
        bus.fc_fd_done = 1'b0; bus.fc_bk_done = noisy & coin();
        bus.m_ready = noisy & coin(); bus.g_ready = noisy & coin(); bus.e_valid = 1'b0;
        tick();
        exp_fin = din;
        set_exp(0, 0, 0, 0, 1, 0);
        bus.s_valid = noisy & coin(); bus.s_data = rnd27(); bus.s_train = coin();
        bus.fc_fd_done = noisy & coin(); bus.fc_bk_done = noisy & coin();
        tick();
        set_exp(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < flat; i++) begin
            bus.fc_fd_done = 1'b0; bus.fc_bk_done = noisy & coin();
            bus.fc_fout = rnd27(); bus.m_ready = noisy & coin();
            tick();
        end
        bus.fc_fd_done = 1'b1; bus.fc_fout = fout; bus.fc_bk_done = noisy & coin();
        bus.m_ready = 1'b0;
        tick();
        exp_mdata = fout;
        set_exp(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < mstall; i++) begin
            bus.m_ready = 1'b0; bus.fc_fd_done = noisy & coin(); bus.fc_fout = rnd27();
            bus.s_valid = noisy & coin();
            tick();
        end
        bus.m_ready = 1'b1; bus.fc_fd_done = noisy & coin(); bus.fc_fout = rnd27();
        tick();
        bus.m_ready = 1'b0;
        if (!train) begin
            exp_steps++;
            set_exp(1, 0, 0, 0, 0, 0);
            clear_inputs();
            return;
        end
        set_exp(0, 0, 1, 0, 0, 0);
        bus.s_valid = 1'b0;
        for (int i = 0; i < egap; i++) begin
            bus.e_valid = 1'b0; bus.e_data = rnd27();
            bus.fc_fd_done = noisy & coin(); bus.fc_bk_done = noisy & coin();
            tick();
        end
        bus.e_valid = 1'b1; bus.e_data = edata; bus.fc_bk_done = 1'b0;
        tick();
        exp_bin = edata;
        set_exp(0, 0, 0, 0, 0, 1);
        bus.e_valid = noisy & coin(); bus.e_data = rnd27(); bus.fc_bk_done = noisy & coin();
        tick();
        set_exp(0, 0, 0, 0, 0, 0);
        bus.e_valid = 1'b0;
        for (int i = 0; i < blat; i++) begin
            bus.fc_bk_done = 1'b0; bus.fc_fd_done = noisy & coin(); bus.fc_bout = rnd27();
            tick();
        end
        if (abort) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
            chk("rst_fd_prop", 32'(bus.fc_fd_prop), 32'd0);
            chk("rst_bk_prop", 32'(bus.fc_bk_prop), 32'd0);
            chk("rst_g_valid", 32'(bus.g_valid), 32'd0);
            chk("rst_step_count", 32'(bus.step_count), 32'd0);
            reset_model();
            clear_inputs();
            return;
        end
        bus.fc_bk_done = 1'b1; bus.fc_bout = bout; bus.fc_fd_done = noisy & coin();
        tick();
        exp_gdata = bout;
        set_exp(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < gstall; i++) begin
            bus.g_ready = 1'b0; bus.fc_bk_done = noisy & coin(); bus.fc_bout = rnd27();
            tick();
        end
        bus.g_ready = 1'b1; bus.fc_bk_done = noisy & coin();
        tick();
        exp_steps++;
        set_exp(1, 0, 0, 0, 0, 0);
        clear_inputs();
    endtask

    initial begin
        int t0, t1;
        bit prev;
        clear_inputs();
        bus.s_data = '0; bus.e_data = '0; bus.fc_fout = '0; bus.fc_bout = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_s_ready", 32'(bus.s_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_m_data", 32'(bus.m_data), 32'd0);
        chk("reset_osc", 32'(bus.fc_oscillator), 32'd0);
        rst_n = 1'b1;

        // Oscillator period measured between two rising edges while idle
        t0 = -1; t1 = -1;
        prev = bus.fc_oscillator;
        for (int c = 0; c < 40 && t1 < 0; c++) begin
            tick();
            if (bus.fc_oscillator && !prev) begin
                if (t0 < 0) t0 = c;
                else t1 = c;
            end
            prev = bus.fc_oscillator;
        end
        chk("osc_period", 32'(t1 - t0), 32'd8);

        // Inference step: done three cycles after the forward strobe
        run_step(27'h5A5A5A5, 1'b0, 27'h1234567, '0, '0, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("inf_m_data", 32'(bus.m_data), 32'h1234567);
        chk("inf_fin", 32'(bus.fc_fin), 32'h5A5A5A5);
        chk("inf_steps", 32'(bus.step_count), 32'd1);
        chk("inf_fd_pulses", 32'(fd_pulses), 32'd1);

        // Training step
        run_step(27'h5A5A5A5, 1'b1, 27'h1234567, 27'h0000001, 27'h7FFFFFF,
                 2, 0, 1, 2, 2, 1'b0, 1'b0);
        chk("trn_g_data", 32'(bus.g_data), 32'h0000001);
        chk("trn_bin", 32'(bus.fc_bin), 32'h7FFFFFF);
        chk("trn_steps", 32'(bus.step_count), 32'd2);
        chk("trn_bk_pulses", 32'(bk_pulses), 32'd1);

        // Backpressure with changing fc_fout and stray done pulses
        run_step(rnd27(), 1'b0, 27'h1234567, '0, '0, 1, 10, 0, 0, 0, 1'b1, 1'b0);
        chk("bp_m_data", 32'(bus.m_data), 32'h1234567);
        chk("bp_steps", 32'(bus.step_count), 32'd3);

        for (int n = 0; n < 40; n++) begin
            idle_cycles(int'($urandom_range(0, 3)));
            run_step(rnd27(), coin(), rnd27(), rnd27(), rnd27(),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 4)), 1'b1, 1'b0);
        end

`ifdef FC_SEQ_TIMEOUT_EN
        // Done on the last permitted wait cycle is still a normal capture
        run_step(rnd27(), 1'b1, 27'h0ABCDEF, 27'h0FEDCBA, rnd27(),
                 TIMEOUT_CYC - 1, 0, 0, TIMEOUT_CYC - 1, 0, 1'b0, 1'b0);
        chk("expiry_err", 32'(bus.err_timeout), 32'd0);
        chk("expiry_g_data", 32'(bus.g_data), 32'h0FEDCBA);

        // No done at all: sticky error, back to idle without a result
        bus.s_valid = 1'b1; bus.s_data = 27'h0123456; bus.s_train = 1'b0;
        tick();
        exp_fin = 27'h0123456;
        set_exp(0, 0, 0, 0, 1, 0);
        bus.s_valid = 1'b0;
        tick();
        set_exp(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < int'(TIMEOUT_CYC); i++) begin
            bus.fc_fd_done = 1'b0; bus.fc_bk_done = coin(); bus.m_ready = coin();
            tick();
        end
        exp_err = 1'b1;
        set_exp(1, 0, 0, 0, 0, 0);
        clear_inputs();
        chk("timeout_err", 32'(bus.err_timeout), 32'd1);
        chk("timeout_idle", 32'(bus.s_ready), 32'd1);
        idle_cycles(3);
`endif

        // Reset dropped mid-cycle while waiting for backward done
        run_step(rnd27(), 1'b1, rnd27(), rnd27(), rnd27(), 1, 0, 0, 3, 0, 1'b0, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_step(rnd27(), 1'b0, 27'h0000F0F, '0, '0, 0, 1, 0, 0, 0, 1'b0, 1'b0);
        chk("post_rst_steps", 32'(bus.step_count), 32'd1);
        chk("post_rst_m_data", 32'(bus.m_data), 32'h0000F0F);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fc_sequencer.md
Name: fc_sequencer

Overview:
- Controller sitting between the host/stream side and one fc network instance.
- Accepts an input vector, pulses the network's forward-propagate strobe, waits for its done signal and returns the forward result.
- For training samples, it then accepts an error vector, runs backward propagation and returns the back-propagated vector.
- Owns the network's fin/bin registers and generates its oscillator signal. Counts completed steps.

Parameters:
- N, 27, vector width; must match the fc instance.
- OSC_DIV, 4, cycles between fc_oscillator toggles; legal range 1..255.
- TIMEOUT_CYC, 1024, maximum cycles spent waiting for a done signal; used only with FC_SEQ_TIMEOUT_EN.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous reset, active-low.
- s_valid  in  1  input vector valid.
- s_ready  out  1  sequencer can accept a new input vector.
- s_data  in  N  input vector.
- s_train  in  1  sampled with s_data; 1 = also run the backward phase.
- m_valid  out  1  forward result valid.
- m_ready  in  1  consumer accepts the forward result.
- m_data  out  N  forward result (captured fc_fout).
- e_valid  in  1  error vector valid.
- e_ready  out  1  sequencer can accept the error vector.
- e_data  in  N  error vector.
- g_valid  out  1  backward result valid.
- g_ready  in  1  consumer accepts the backward result.
- g_data  out  N  backward result (captured fc_bout).
- fc_fd_prop  out  1  one-cycle forward-start strobe.
- fc_bk_prop  out  1  one-cycle backward-start strobe.
- fc_fin  out  N  registered forward input.
- fc_bin  out  N  registered backward input.
- fc_oscillator  out  1  oscillator drive to the network.
- fc_fout  in  N  network forward output.
- fc_bout  in  N  network backward output.
- fc_fd_done  in  1  forward done.
- fc_bk_done  in  1  backward done.
- busy  out  1  state is not IDLE.
- step_count  out  16  completed steps; wraps from 0xFFFF to 0.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except s_ready, which is 1.
  - fc_fin, fc_bin, m_data, g_data, step_count, the oscillator counter and err_timeout are all cleared.
- States: IDLE, FWD_START, FWD_WAIT, FWD_OUT, ERR_WAIT, BK_START, BK_WAIT, BK_OUT.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: fc_fin<=s_data, train_q<=s_train, go to FWD_START.
- FWD_START:
  - fc_fd_prop=1 for exactly this cycle, then go to FWD_WAIT.
  - fc_fd_done is ignored in this cycle.
- FWD_WAIT:
  - On the first cycle with fc_fd_done=1: m_data<=fc_fout, go to FWD_OUT.
  - Result: m_valid rises on the cycle after done is seen.
- FWD_OUT:
  - m_valid=1; m_data is held stable until m_ready.
  - On m_valid&m_ready with train_q=1: go to ERR_WAIT.
  - On m_valid&m_ready with train_q=0: step_count+1, go to IDLE.
- ERR_WAIT:
  - e_ready=1.
  - On e_valid&e_ready: fc_bin<=e_data, go to BK_START.
- BK_START: fc_bk_prop=1 for one cycle, then go to BK_WAIT.
- BK_WAIT: on fc_bk_done=1: g_data<=fc_bout, go to BK_OUT.
- BK_OUT:
  - g_valid=1.
  - On g_valid&g_ready: step_count+1, go to IDLE.
- Latency:
  - s handshake to fc_fd_prop: 1 cycle.
  - done to m_valid (or g_valid): 1 cycle.
  - m handshake to IDLE (s_ready=1): 1 cycle. No back-to-back acceptance in the handshake cycle.
- Handshake outputs:
  - s_ready, e_ready, m_valid and g_valid are decoded from the registered state only.
  - None of them depends combinationally on any input.
- fc_fin/fc_bin are held constant from capture until the next capture.
- Spurious done signals: fc_fd_done or fc_bk_done asserted in any other state is ignored.
- Oscillator:
  - A free-running counter 0..OSC_DIV-1 runs in all states.
  - fc_oscillator toggles when the counter wraps.
  - OSC_DIV=1 toggles every cycle.
- Reset mid-operation: any state returns to IDLE immediately. In-flight data is discarded; no strobe is emitted.

Optional Feature:
- Macro: FC_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FWD_WAIT/BK_WAIT and increments each cycle spent there.
  - If it reaches TIMEOUT_CYC without done, the sequencer sets err_timeout=1 (sticky until reset) and goes to IDLE.
  - m_valid/g_valid are not raised and step_count does not change.
  - A done arriving in the same cycle as expiry wins: normal capture, no error.
- Not defined:
  - No wait counter; the wait states are held indefinitely.
  - err_timeout is tied to 0.

Test Plan:
- Inference step:
  - Stimulus: s_data=27'h5A5A5A5, s_train=0; fd_done 3 cycles after fc_fd_prop with fc_fout=27'h1234567.
  - Response: fc_fin=27'h5A5A5A5; single-cycle fc_fd_prop; m_valid 1 cycle after done with m_data=27'h1234567; step_count 0->1.
- Training step:
  - Stimulus: as above with s_train=1; e_data=27'h7FFFFFF; fc_bout=27'h0000001.
  - Response: fc_bk_prop pulses once; g_data=27'h0000001; step_count incremented only after g handshake.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles while fc_fout changes.
  - Response: m_data stays 27'h1234567; s_ready=0 throughout; fc_fd_done pulses ignored.
- Reset mid-operation:
  - Stimulus: drop rst_in during BK_WAIT.
  - Response: busy=0, all strobes 0, step_count=0, s_ready=1 asynchronously.
- Oscillator:
  - Stimulus: OSC_DIV=4.
  - Response: fc_oscillator period 8 cycles, running independent of state.
- Timeout (with FC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: no fd_done.
  - Response: err_timeout=1 after 16 wait cycles, back to IDLE, no m_valid.
  - Stimulus: done on the expiry cycle.
  - Response: normal capture, err_timeout=0.
